rx_frame_splitter: RTL
======================

// Module: rx_frame_splitter
// PURPOSE
//  Upstream neighbour of the control-frame fetcher. Takes the per-port MAC RX byte stream, splits each
//  frame into a 128-bit header word (H_FIFO) and a 9-bit body byte stream (B_FIFO), and tags link-local
//  control frames (dst 01:80:C2:00:00:0x) so the fetcher can pick them out. Header is pushed only after
//  the frame's last body byte, so a visible header always has a complete body.
// PARAMETERS
//  PORT_ID  0     2-bit source port number, copied into header[113:112]
//  MAX_LEN  1518  frames longer than this are truncated (bytes, incl. 14-byte L2 header), range 15..2047
//  MIN_LEN  15    frames shorter than this are discarded silently (runts), min 15
// PORTS
//  clk          in   1    clock
//  arst_n       in   1    asynchronous active-low reset
//  rx_data      in   8    received byte
//  rx_valid     in   1    rx_data valid this cycle (no backpressure possible)
//  rx_sop       in   1    first byte of frame, qualified by rx_valid
//  rx_eop       in   1    last byte of frame, qualified by rx_valid
//  rx_err       in   1    frame bad (CRC/PHY), sampled with rx_eop
//  h_fifo_din   out  128  header word
//  h_fifo_wren  out  1    header push
//  h_fifo_full  in   1    header FIFO full
//  b_fifo_din   out  9    {delimiter, byte}; bit8=1 on last body byte of frame
//  b_fifo_wren  out  1    body push
//  b_fifo_afull in   1    body FIFO has < MAX_LEN free entries
//  drop_cnt     out  16   frames dropped for lack of space or protocol error, saturates at 0xFFFF
// BEHAVIOUR
//  - Reset: all outputs 0, state S_IDLE, byte counter 0, drop_cnt 0. Reset mid-frame abandons frame with
//    no further FIFO writes; partial body already in B_FIFO is the system reset's problem (FIFOs reset too).
//  - Header layout: [127]=error, [126:116]=length (bytes received, max MAX_LEN), [115]=truncated,
//    [114]=ctrl (dst==01:80:C2:00:00:0x, low nibble any), [113:112]=PORT_ID, [111:64]=dst MAC,
//    [63:16]=src MAC, [15:0]=ethertype; all big-endian as on the wire (byte 0 -> [111:104]).
//  - Body = frame bytes 14..end. All FIFO outputs registered: one cycle from rx beat to wren.
//  - States: S_IDLE, S_HDR (bytes 0..13, shift into header reg), S_BODY, S_DROP.
//  - S_IDLE: rx_valid&rx_sop -> if h_fifo_full|b_fifo_afull: drop_cnt++, S_DROP; else capture byte 0, S_HDR.
//    rx_valid without sop in S_IDLE: ignored.
//  - S_HDR: eop before byte 14 -> runt, no writes, no drop_cnt, S_IDLE. After byte 13 -> S_BODY.
//    sop in S_HDR: restart header capture with this byte (nothing was written), drop_cnt++.
//  - S_BODY: each valid byte -> b_fifo_wren=1, din={eop,byte}. On eop: also h_fifo_wren=1 in the SAME
//    output cycle as the delimiter byte, header[127]=rx_err, length=count incl. eop byte; -> S_IDLE.
//    Frames of length < MIN_LEN ending in S_BODY (MIN_LEN>15) also commit normally (body already written).
//  - Truncation: byte at count MAX_LEN-1 written with delimiter=1, header pushed with [115]=1, [127]=1;
//    -> S_DROP to swallow remaining bytes up to eop (no drop_cnt).
//  - sop in S_BODY (missing eop): write pad byte {1,8'h00} as delimiter, push header with [127]=1,
//    drop_cnt++ for the new frame, -> S_DROP (new frame discarded).
//  - S_DROP: ignore bytes; rx_valid&rx_eop -> S_IDLE. sop in S_DROP: stay in S_DROP.
//  - sop&eop same beat: one-byte runt, discarded. Byte counter 11 bits, never exceeds MAX_LEN.
//  - At most one h push and one b push per cycle; h_fifo_full/b_fifo_afull checked only at sop.
// TESTING
//  - 64-byte frame dst 01:80:C2:00:00:00, PORT_ID=1 -> header [114]=1,[113:112]=1,len=64,err=0;
//    50 body bytes, delimiter on 50th only; h_fifo_wren same cycle as delimiter write.
//  - 60-byte frame dst 00:11:22:33:44:55 with rx_err at eop -> [114]=0,[127]=1, len=60, 46 body bytes.
//  - 10-byte runt, then 64-byte frame back-to-back (sop next cycle after eop) -> no writes for runt,
//    second frame intact, drop_cnt=0.
//  - 1600-byte frame, MAX_LEN=1518 -> 1504 body bytes, delimiter on last, header len=1518,[115]=1,[127]=1.
//  - b_fifo_afull=1 at sop -> no writes, drop_cnt 0->1; frame following with afull=0 accepted.
//  - sop at body byte 20 w/o eop -> pad {1,00} written, header err=1, drop_cnt=1; async reset mid-frame ->
//    all outputs 0 next edge, next clean frame passes.

Source files
------------

// File: rtl/rx_frame_splitter_if.sv
// Bundles the MAC RX byte stream, the header/body FIFO write ports and the
// drop counter of one rx_frame_splitter instance.
// master: the environment (MAC + FIFOs); slave: the splitter itself.
interface rx_frame_splitter_if;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_sop;
    logic         rx_eop;
    logic         rx_err;
    logic [127:0] h_fifo_din;
    logic         h_fifo_wren;
    logic         h_fifo_full;
    logic [8:0]   b_fifo_din;
    logic         b_fifo_wren;
    logic         b_fifo_afull;
    logic [15:0]  drop_cnt;

    modport master (
        output rx_data, rx_valid, rx_sop, rx_eop, rx_err, h_fifo_full, b_fifo_afull,
        input  h_fifo_din, h_fifo_wren, b_fifo_din, b_fifo_wren, drop_cnt
    );

    modport slave (
        input  rx_data, rx_valid, rx_sop, rx_eop, rx_err, h_fifo_full, b_fifo_afull,
        output h_fifo_din, h_fifo_wren, b_fifo_din, b_fifo_wren, drop_cnt
    );
endinterface

// File: rtl/rx_frame_splitter.sv
// Splits each received frame into a 128-bit header word and a delimited body
// byte stream. The header is pushed together with the last body byte, so a
// header visible in H_FIFO always has its complete body in B_FIFO.
module rx_frame_splitter #(
    parameter int unsigned PORT_ID = 0,
    parameter int unsigned MAX_LEN = 1518,
    parameter int unsigned MIN_LEN = 15
) (
    input  logic               clk,
    input  logic               arst_n,
    rx_frame_splitter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_DROP} state_t;

    localparam logic [10:0] LAST_IDX    = 11'(MAX_LEN - 1);
    localparam logic [10:0] HDR_LAST    = 11'd13;
    localparam logic [1:0]  PORT_BITS   = 2'(PORT_ID);
    // 01:80:C2:00:00:0x with the low nibble of the last byte left open
    localparam logic [43:0] CTRL_DST_HI = 44'h0180C200000;

    // Frames shorter than 15 bytes never leave S_HDR, so MIN_LEN only has to
    // be sane; longer short frames commit like any other frame.
    generate
        if (MIN_LEN < 15 || MAX_LEN < 15 || MAX_LEN > 2047 || MIN_LEN > MAX_LEN || PORT_ID > 3) begin : g_param_check
            $error("rx_frame_splitter: parameter out of range");
        end
    endgenerate

    state_t        state_reg, state_next;
    logic [10:0]   cnt_reg, cnt_next;
    logic [111:0]  hdr_reg, hdr_next;
    logic [127:0]  h_din_reg, h_din_next;
    logic          h_wren_reg, h_wren_next;
    logic [8:0]    b_din_reg, b_din_next;
    logic          b_wren_reg, b_wren_next;
    logic [15:0]   drop_reg, drop_next;
    logic          drop_inc;
    logic          sop, eop, ctrl_hit, at_limit;

    assign sop      = bus.rx_valid & bus.rx_sop;
    assign eop      = bus.rx_valid & bus.rx_eop;
    assign ctrl_hit = (hdr_reg[111:68] == CTRL_DST_HI);
    assign at_limit = (cnt_reg == LAST_IDX);

    function automatic logic [127:0] make_hdr(input logic err, input logic [10:0] len,
                                              input logic trunc, input logic ctrl,
                                              input logic [111:0] fields);
        return {err, len, trunc, ctrl, PORT_BITS, fields};
    endfunction

    // Next-state, header capture, FIFO write and drop decisions for one beat
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        hdr_next    = hdr_reg;
        h_din_next  = h_din_reg;
        h_wren_next = 1'b0;
        b_din_next  = b_din_reg;
        b_wren_next = 1'b0;
        drop_inc    = 1'b0;
        drop_next   = drop_reg;

        case (state_reg)
            S_IDLE: begin
                // sop&eop on the same beat is a one-byte runt: nothing to do
                if (sop && !eop) begin
                    if (bus.h_fifo_full || bus.b_fifo_afull) begin
                        drop_inc   = 1'b1;
                        state_next = S_DROP;
                    end else begin
                        hdr_next   = {104'd0, bus.rx_data};
                        cnt_next   = 11'd1;
                        state_next = S_HDR;
                    end
                end
            end
            S_HDR: begin
                if (sop) begin
                    // Nothing was written yet, so restart on the new frame
                    drop_inc   = 1'b1;
                    hdr_next   = {104'd0, bus.rx_data};
                    cnt_next   = 11'd1;
                    state_next = eop ? S_IDLE : S_HDR;
                end else if (eop) begin
                    state_next = S_IDLE;
                end else if (bus.rx_valid) begin
                    hdr_next = {hdr_reg[103:0], bus.rx_data};
                    cnt_next = cnt_reg + 11'd1;
                    if (cnt_reg == HDR_LAST) begin
                        state_next = S_BODY;
                    end
                end
            end
            S_BODY: begin
                if (sop) begin
                    // Missing eop: close the old frame with a pad delimiter
                    b_wren_next = 1'b1;
                    b_din_next  = {1'b1, 8'h00};
                    h_wren_next = 1'b1;
                    h_din_next  = make_hdr(1'b1, cnt_reg, 1'b0, ctrl_hit, hdr_reg);
                    drop_inc    = 1'b1;
                    state_next  = eop ? S_IDLE : S_DROP;
                end else if (bus.rx_valid) begin
                    b_wren_next = 1'b1;
                    b_din_next  = {eop | at_limit, bus.rx_data};
                    cnt_next    = cnt_reg + 11'd1;
                    if (eop) begin
                        h_wren_next = 1'b1;
                        h_din_next  = make_hdr(bus.rx_err, cnt_reg + 11'd1, 1'b0, ctrl_hit, hdr_reg);
                        state_next  = S_IDLE;
                    end else if (at_limit) begin
                        h_wren_next = 1'b1;
                        h_din_next  = make_hdr(1'b1, cnt_reg + 11'd1, 1'b1, ctrl_hit, hdr_reg);
                        state_next  = S_DROP;
                    end
                end
            end
            S_DROP: begin
                if (eop) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (drop_inc && (drop_reg != 16'hFFFF)) begin
            drop_next = drop_reg + 16'd1;
        end
    end

    // State, counters and registered FIFO outputs
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= 11'd0;
            hdr_reg    <= 112'd0;
            h_din_reg  <= 128'd0;
            h_wren_reg <= 1'b0;
            b_din_reg  <= 9'd0;
            b_wren_reg <= 1'b0;
            drop_reg   <= 16'd0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            hdr_reg    <= hdr_next;
            h_din_reg  <= h_din_next;
            h_wren_reg <= h_wren_next;
            b_din_reg  <= b_din_next;
            b_wren_reg <= b_wren_next;
            drop_reg   <= drop_next;
        end
    end

    assign bus.h_fifo_din  = h_din_reg;
    assign bus.h_fifo_wren = h_wren_reg;
    assign bus.b_fifo_din  = b_din_reg;
    assign bus.b_fifo_wren = b_wren_reg;
    assign bus.drop_cnt    = drop_reg;
endmodule
